clk_period_meter: RTL and testbench

Measures the high time, low time and full period of a slow, asynchronous square-wave input in `I_CLK` cycles. It is the receiving end of our divided-clock path: the divider generates slow clocks, and this block recovers their timing. It is used to check the divider's output, and the camera's frame or line strobes, against expectations. Results are published once per completed period with a one-cycle valid strobe, and a stalled input is flagged by a timeout.

---
 rtl/clk_period_meter.sv | 137 +++++++++++++
 tb/tb_clk_period_meter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_period_meter.sv
// clk_period_meter
//   Measures the high time, low time and full period of a slow square wave
//   that is asynchronous to I_CLK, counted in I_CLK cycles. A new result is
//   published at each rising edge that closes a full high+low pair. If no edge
//   is seen for TIMEOUT cycles, O_TIMEOUT is raised and stays high until the
//   next published result.
//
// Parameters
//   CNT_W    width of the high/low counts
//   TIMEOUT  idle cycles before O_TIMEOUT asserts (2 <= TIMEOUT <= 2**CNT_W-1)
//
// Ports
//   I_CLK      system clock, rising edge
//   rst        synchronous reset, active high
//   I_SIG      measured signal, asynchronous to I_CLK
//   O_HIGH     last measured high time (cycles)
//   O_LOW      last measured low time (cycles)
//   O_PERIOD   O_HIGH + O_LOW of the same measurement
//   O_VALID    one-cycle strobe when O_HIGH/O_LOW/O_PERIOD update
//   O_TIMEOUT  level, input stalled
module clk_period_meter #(
  parameter int CNT_W   = 24,
  parameter int TIMEOUT = 10_000_000
) (
  input  logic             I_CLK,
  input  logic             rst,
  input  logic             I_SIG,
  output logic [CNT_W-1:0] O_HIGH,
  output logic [CNT_W-1:0] O_LOW,
  output logic [CNT_W:0]   O_PERIOD,
  output logic             O_VALID,
  output logic             O_TIMEOUT
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HIGH,
    S_LOW
  } state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

  logic             s1, s2, s3;
  logic             rise, fall, edge_det;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] high_tmp;
  logic             timeout_hit;
  logic             cap_high;
  logic             publish;
  state_t           state, state_nxt;

  // s1/s2 resynchronise I_SIG; s3 holds the previous s2 for edge detection.
  assign rise     = s2 & ~s3;
  assign fall     = ~s2 & s3;
  assign edge_det = rise | fall;

  // An edge in the same cycle as the count reaching TIMEOUT wins: the interval
  // is exactly TIMEOUT long and is a valid measurement, not a stall.
  assign timeout_hit = (cnt == TIMEOUT_C) && !edge_det;

  // NOTE: every output of this block gets a default before the case so no
  // path leaves a signal unassigned, which would infer a latch.
  always_comb begin
    state_nxt = state;
    cap_high  = 1'b0;
    publish   = 1'b0;
    if (timeout_hit) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          // A fall while idle only restarts the interval counter.
          if (rise) state_nxt = S_HIGH;
        end
        S_HIGH: begin
          if (fall) begin
            cap_high  = 1'b1;
            state_nxt = S_LOW;
          end
        end
        S_LOW: begin
          if (rise) begin
            publish   = 1'b1;
            state_nxt = S_HIGH;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge I_CLK) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // NOTE: all sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, which the s1->s2->s3 chain depends on.
  always_ff @(posedge I_CLK) begin
    if (rst) begin
      s1        <= 1'b0;
      s2        <= 1'b0;
      s3        <= 1'b0;
      cnt       <= '0;
      high_tmp  <= '0;
      O_HIGH    <= '0;
      O_LOW     <= '0;
      O_PERIOD  <= '0;
      O_VALID   <= 1'b0;
      O_TIMEOUT <= 1'b0;
    end else begin
      s1 <= I_SIG;
      s2 <= s1;
      s3 <= s2;

      // Reload to 1 so that the count seen in the cycle of the next edge
      // equals the edge-to-edge distance; saturate at TIMEOUT.
      if (edge_det)              cnt <= ONE_C;
      else if (cnt != TIMEOUT_C) cnt <= cnt + ONE_C;

      if (cap_high)         high_tmp <= cnt;
      else if (timeout_hit) high_tmp <= '0;

      O_VALID <= publish;
      if (publish) begin
        O_HIGH    <= high_tmp;
        O_LOW     <= cnt;
        O_PERIOD  <= {1'b0, high_tmp} + {1'b0, cnt};
        O_TIMEOUT <= 1'b0;
      end else if (timeout_hit) begin
        O_TIMEOUT <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_clk_period_meter.sv
// tb_clk_period_meter
//   Directed bench for clk_period_meter. Four instances share clock, reset and
//   input, each with a different TIMEOUT (u0: 5000, u1: 100, u2: 50,
//   u3: 20 with CNT_W = 8); each scenario observes one of them through sel.
module tb_clk_period_meter;

  logic I_CLK = 1'b0;
  logic rst   = 1'b1;
  logic sig   = 1'b0;

  logic [23:0] u0_high, u0_low, u1_high, u1_low, u2_high, u2_low;
  logic [24:0] u0_period, u1_period, u2_period;
  logic [7:0]  u3_high, u3_low;
  logic [8:0]  u3_period;
  logic        u0_valid, u1_valid, u2_valid, u3_valid;
  logic        u0_to, u1_to, u2_to, u3_to;

  always #5 I_CLK = ~I_CLK;

  clk_period_meter #(.CNT_W(24), .TIMEOUT(5000)) u0 (
    .I_CLK(I_CLK), .rst(rst), .I_SIG(sig), .O_HIGH(u0_high), .O_LOW(u0_low),
    .O_PERIOD(u0_period), .O_VALID(u0_valid), .O_TIMEOUT(u0_to));
  clk_period_meter #(.CNT_W(24), .TIMEOUT(100)) u1 (
    .I_CLK(I_CLK), .rst(rst), .I_SIG(sig), .O_HIGH(u1_high), .O_LOW(u1_low),
    .O_PERIOD(u1_period), .O_VALID(u1_valid), .O_TIMEOUT(u1_to));
  clk_period_meter #(.CNT_W(24), .TIMEOUT(50)) u2 (
    .I_CLK(I_CLK), .rst(rst), .I_SIG(sig), .O_HIGH(u2_high), .O_LOW(u2_low),
    .O_PERIOD(u2_period), .O_VALID(u2_valid), .O_TIMEOUT(u2_to));
  clk_period_meter #(.CNT_W(8), .TIMEOUT(20)) u3 (
    .I_CLK(I_CLK), .rst(rst), .I_SIG(sig), .O_HIGH(u3_high), .O_LOW(u3_low),
    .O_PERIOD(u3_period), .O_VALID(u3_valid), .O_TIMEOUT(u3_to));

  int          sel = 0;
  logic [31:0] obs_high, obs_low, obs_period;
  logic        obs_valid, obs_timeout;

  always_comb begin
    obs_high    = '0;
    obs_low     = '0;
    obs_period  = '0;
    obs_valid   = 1'b0;
    obs_timeout = 1'b0;
    case (sel)
      0: begin obs_high = 32'(u0_high); obs_low = 32'(u0_low); obs_period = 32'(u0_period);
               obs_valid = u0_valid; obs_timeout = u0_to; end
      1: begin obs_high = 32'(u1_high); obs_low = 32'(u1_low); obs_period = 32'(u1_period);
               obs_valid = u1_valid; obs_timeout = u1_to; end
      2: begin obs_high = 32'(u2_high); obs_low = 32'(u2_low); obs_period = 32'(u2_period);
               obs_valid = u2_valid; obs_timeout = u2_to; end
      default: begin obs_high = 32'(u3_high); obs_low = 32'(u3_low); obs_period = 32'(u3_period);
               obs_valid = u3_valid; obs_timeout = u3_to; end
    endcase
  end

  int checks = 0;
  int errors = 0;

  // Wave monitor state, used by step() while a scenario drives I_SIG.
  logic [31:0] exp_h, exp_l;
  int          mon_cyc, mon_last, mon_nvalid, mon_to_seen;
  logic        mon_prev_to, mon_to_before;

  task automatic do_reset();
    sig = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge I_CLK);
    rst = 1'b0;
  endtask

  task automatic mon_reset(input logic [31:0] h, input logic [31:0] l);
    exp_h         = h;
    exp_l         = l;
    mon_cyc       = 0;
    mon_last      = -1;
    mon_nvalid    = 0;
    mon_to_seen   = 0;
    mon_prev_to   = 1'b0;
    mon_to_before = 1'b0;
  endtask

  // One cycle: sample outputs at the falling edge, then drive the next level.
  task automatic step(input logic v);
    @(negedge I_CLK);
    mon_cyc++;
    if (obs_valid) begin
      checks += 4;
      if (obs_high !== exp_h)
        begin errors++; $display("FAIL high: got %0d expected %0d", obs_high, exp_h); end
      if (obs_low !== exp_l)
        begin errors++; $display("FAIL low: got %0d expected %0d", obs_low, exp_l); end
      if (obs_period !== exp_h + exp_l)
        begin errors++; $display("FAIL period: got %0d expected %0d", obs_period, exp_h + exp_l); end
      if (obs_timeout !== 1'b0)
        begin errors++; $display("FAIL timeout_at_valid: got %0b expected 0", obs_timeout); end
      if (mon_last >= 0) begin
        checks++;
        if (mon_cyc - mon_last != int'(exp_h + exp_l))
          begin errors++; $display("FAIL valid_spacing: got %0d expected %0d", mon_cyc - mon_last, exp_h + exp_l); end
      end
      if (mon_nvalid == 0) mon_to_before = mon_prev_to;
      mon_last = mon_cyc;
      mon_nvalid++;
    end
    if (obs_timeout) mon_to_seen++;
    mon_prev_to = obs_timeout;
    sig = v;
  endtask

  // Optional low lead-in, then `periods` high/low pairs, then the closing rise
  // held long enough for its result to appear.
  task automatic run_wave(input int h, input int l, input int periods, input int lead_low);
    for (int i = 0; i < lead_low; i++) step(1'b0);
    for (int p = 0; p < periods; p++) begin
      for (int i = 0; i < h; i++) step(1'b1);
      for (int i = 0; i < l; i++) step(1'b0);
    end
    repeat (5) step(1'b1);
  endtask

  task automatic check_count(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  task automatic test_reset();
    do_reset();
    for (int s = 0; s < 4; s++) begin
      sel = s;
      #1;
      checks += 3;
      if (obs_high !== 32'd0 || obs_low !== 32'd0 || obs_period !== 32'd0)
        begin errors++; $display("FAIL reset_data u%0d: got %0d/%0d/%0d expected 0/0/0", s, obs_high, obs_low, obs_period); end
      if (obs_valid !== 1'b0)
        begin errors++; $display("FAIL reset_valid u%0d: got %0b expected 0", s, obs_valid); end
      if (obs_timeout !== 1'b0)
        begin errors++; $display("FAIL reset_timeout u%0d: got %0b expected 0", s, obs_timeout); end
    end
  endtask

  task automatic test_divider();
    sel = 0;
    do_reset();
    mon_reset(1000, 1000);
    run_wave(1000, 1000, 5, 0);
    check_count("divider_valid_count", mon_nvalid, 5);
    check_count("divider_timeout_cycles", mon_to_seen, 0);
  endtask

  task automatic test_asymmetric(input int h, input int l, input int periods);
    sel = 0;
    do_reset();
    mon_reset(32'(h), 32'(l));
    run_wave(h, l, periods, 0);
    check_count("asym_valid_count", mon_nvalid, periods);
    check_count("asym_timeout_cycles", mon_to_seen, 0);
  endtask

  task automatic test_stuck();
    int first_to = 0;
    int nvalid   = 0;
    int nonzero  = 0;
    sel = 1;
    do_reset();
    for (int n = 1; n <= 300; n++) begin
      @(negedge I_CLK);
      if (obs_timeout && first_to == 0) first_to = n;
      if (obs_valid) nvalid++;
      if (obs_high != 0 || obs_low != 0 || obs_period != 0) nonzero++;
    end
    check_count("stuck_timeout_edge", first_to, 101);
    check_count("stuck_valid_pulses", nvalid, 0);
    check_count("stuck_nonzero_data", nonzero, 0);
  endtask

  task automatic test_stall();
    sel = 2;
    do_reset();
    mon_reset(10, 10);
    run_wave(10, 10, 3, 0);
    check_count("stall_valid_count", mon_nvalid, 3);
    repeat (70) step(1'b1);
    check_count("stall_no_valid_in_hold", mon_nvalid, 3);
    checks += 2;
    if (obs_timeout !== 1'b1)
      begin errors++; $display("FAIL stall_timeout: got %0b expected 1", obs_timeout); end
    if (obs_high !== 32'd10 || obs_low !== 32'd10 || obs_period !== 32'd20)
      begin errors++; $display("FAIL stall_hold_data: got %0d/%0d/%0d expected 10/10/20", obs_high, obs_low, obs_period); end
    mon_reset(7, 9);
    run_wave(7, 9, 1, 9);
    check_count("resume_valid_count", mon_nvalid, 1);
    checks++;
    if (mon_to_before !== 1'b1)
      begin errors++; $display("FAIL resume_timeout_before_valid: got %0b expected 1", mon_to_before); end
  endtask

  task automatic test_edge_timeout();
    sel = 3;
    do_reset();
    mon_reset(20, 20);
    run_wave(20, 20, 3, 0);
    check_count("coincident_valid_count", mon_nvalid, 3);
    check_count("coincident_timeout_cycles", mon_to_seen, 0);
  endtask

  task automatic test_reset_mid();
    sel = 0;
    do_reset();
    mon_reset(6, 4);
    run_wave(6, 4, 2, 0);
    check_count("midrst_valid_before", mon_nvalid, 2);
    step(1'b1);
    repeat (5) step(1'b0);
    rst = 1'b1;
    @(negedge I_CLK);
    rst = 1'b0;
    checks += 2;
    if (obs_high !== 32'd0 || obs_low !== 32'd0 || obs_period !== 32'd0)
      begin errors++; $display("FAIL midrst_data: got %0d/%0d/%0d expected 0/0/0", obs_high, obs_low, obs_period); end
    if (obs_valid !== 1'b0)
      begin errors++; $display("FAIL midrst_valid: got %0b expected 0", obs_valid); end
    mon_reset(5, 3);
    run_wave(5, 3, 2, 3);
    check_count("midrst_valid_after", mon_nvalid, 2);
    check_count("midrst_timeout_cycles", mon_to_seen, 0);
  endtask

  initial begin
    test_reset();
    test_divider();
    test_asymmetric(3, 5, 4);
    test_asymmetric(1, 1, 6);
    test_stuck();
    test_stall();
    test_edge_timeout();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
